// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear/invert with registered complement and flags.
// Optional registered even-parity output enabled by UNIV_SHIFT_REG_PARITY_EN.
module univ_shift_reg #(
    parameter int          WIDTH   = 8,
    parameter logic [63:0] RST_VAL = 64'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qb,
    output logic             so_r,
    output logic             so_l,
    output logic             zero
`ifdef UNIV_SHIFT_REG_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam logic [WIDTH-1:0] RST_Q = RST_VAL[WIDTH-1:0];

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_SHR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_CLR  = 3'b110;
    localparam logic [2:0] M_INV  = 3'b111;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] qb_q, qb_d;
    logic             zero_q, zero_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            unique case (mode)
                M_HOLD: q_d = q_q;
                M_SHR:  q_d = {sin_r, q_q[WIDTH-1:1]};
                M_SHL:  q_d = {q_q[WIDTH-2:0], sin_l};
                M_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
                M_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                M_LOAD: q_d = d;
                M_CLR:  q_d = '0;
                M_INV:  q_d = ~q_q;
            endcase
        end
        // Flags derive from the next value so they never lag q.
        qb_d   = ~q_d;
        zero_d = (q_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q    <= RST_Q;
            qb_q   <= ~RST_Q;
            zero_q <= (RST_Q == '0);
        end else begin
            q_q    <= q_d;
            qb_q   <= qb_d;
            zero_q <= zero_d;
        end
    end

`ifdef UNIV_SHIFT_REG_PARITY_EN
    logic parity_q, parity_d;

    always_comb begin
        parity_d = ^q_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= ^RST_Q;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;
`endif

    assign q    = q_q;
    assign qb   = qb_q;
    assign zero = zero_q;
    assign so_r = q_q[0];
    assign so_l = q_q[WIDTH-1];

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised universal shift register: a WIDTH-bit register with true/complement outputs and eight operating modes (hold, shift, rotate, load, clear, invert) selected per cycle. It generalises the single-bit D flip-flop cell into the datapath register used for serial/parallel conversion, bit-serial arithmetic operands and pattern generation in the lab's CMOS designs.

## Interface
Parameters:
- WIDTH, 8, register width in bits; legal range 2..64
- RST_VAL, 0, value loaded into q on reset (WIDTH bits, truncated if wider)

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  cycle enable; 0 forces hold regardless of mode
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  parallel load data
- sin_r  input  1  serial input entering at MSB on shift right
- sin_l  input  1  serial input entering at LSB on shift left
- q  output  WIDTH  register contents
- qb  output  WIDTH  bitwise complement of q, registered
- so_r  output  1  serial out for right shift, equals q[0]
- so_l  output  1  serial out for left shift, equals q[WIDTH-1]
- zero  output  1  registered flag, 1 when q is all zeros
- parity  output  1  registered even-parity of q (only with UNIV_SHIFT_REG_PARITY_EN)

## Operation
- Reset (rst=1, asynchronous, immediate): q=RST_VAL, qb=~RST_VAL, zero=(RST_VAL==0), parity=^RST_VAL. Reset dominates en and mode.
- en=0: all registers hold.
- en=1, on rising clk, q_next by mode:
  - 000 hold: q
  - 001 shift right: {sin_r, q[WIDTH-1:1]}
  - 010 shift left: {q[WIDTH-2:0], sin_l}
  - 011 rotate right: {q[0], q[WIDTH-1:1]}
  - 100 rotate left: {q[WIDTH-2:0], q[WIDTH-1]}
  - 101 parallel load: d
  - 110 synchronous clear: all zeros (not RST_VAL)
  - 111 invert: ~q
- qb, zero, parity are computed from q_next and registered on the same edge as q; they are never one cycle stale relative to q.
- so_r and so_l are combinational taps of q (no extra register).
- Serial inputs are ignored in all modes except 001/010.
- No X propagation: mode values are fully decoded; no default-to-X case.

## Timing
- Latency: one clock from inputs sampled to q/qb/zero/parity update.
- Shifting a WIDTH-bit word fully through takes WIDTH enabled cycles; bit entering at sin_r appears at so_r after WIDTH enabled shift-right cycles.
- en toggling mid-sequence pauses the operation without corrupting state; no cycles are lost or duplicated.
- Reset asserted mid-shift: outputs go to reset values asynchronously; reset release must meet recovery time to clk; first operation executes on the first rising edge with rst=0.
- Mode change takes effect on the very next enabled edge; no pipeline between modes.

## Configuration
- UNIV_SHIFT_REG_PARITY_EN defined: parity port present; registered, updated with q, reset to ^RST_VAL.
- Not defined: parity port and its register are absent; all other behaviour identical.

## Test plan
- WIDTH=8, RST_VAL=8'hA5, rst pulse between clock edges -> q=A5, qb=5A, zero=0 immediately, before next edge.
- Load d=8'h81 (mode 101), then 8× shift right with sin_r=0 -> q sequence 40,20,10,08,04,02,01,00; so_r=1 at start and after 7 shifts; zero=1 after 8th edge.
- q=8'h81, rotate left ×1 -> 03; rotate right ×2 from 03 -> C0; qb always ~q same cycle.
- q=8'h0F, en=0 with mode 111 for 3 edges -> q stays 0F; then en=1 -> q=F0, qb=0F.
- Mid-sequence shift-left with sin_l=1 from 00 for 4 edges, then rst asserted -> q returns to RST_VAL asynchronously; after release, mode 110 -> q=00, zero=1.
- With UNIV_SHIFT_REG_PARITY_EN: load 8'h07 -> parity=1; load 8'h03 -> parity=0; invert 8'h03 -> FC, parity=0.
